interleaver_4_4_ctrl: RTL

Stream-side sequencer that drives interleaver_4_4 and collects its output.
- Accepts bytes on a valid/ready input stream and writes 16-byte frames into the interleaver (write_i, addr 0..15).
- Issues the 16 interleaved reads (leaver_i, addr 0..15) and captures the one-cycle-latency data_o into a 2-entry output FIFO.
- Presents the permuted frame on a valid/ready output stream with an end-of-frame marker.
- Sits between the byte source (upstream) and the next stage (downstream), with interleaver_4_4 as its memory.

---
 rtl/interleaver_pkg.sv | 19 +
 rtl/il_out_fifo.sv | 43 ++++
 rtl/interleaver_4_4_ctrl.sv | 122 ++++++++++++
 3 files changed

// File: rtl/interleaver_pkg.sv
// Shared widths, FSM encoding and FIFO entry layout for the interleaver stream sequencer.
package interleaver_pkg;

    localparam int unsigned DW      = 8;
    localparam int unsigned FRAME   = 16;
    localparam int unsigned ADDR_W  = 4;
    localparam int unsigned ENTRY_W = DW + 1;

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    typedef struct packed {
        logic          last;
        logic [DW-1:0] data;
    } fifo_entry_t;

endpackage

// File: rtl/il_out_fifo.sv
// Two-entry synchronous FIFO holding {last, data} between the interleaver read port and the output stream.
module il_out_fifo
    import interleaver_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push,
    input  logic               pop,
    input  logic [ENTRY_W-1:0] din,
    output logic [ENTRY_W-1:0] dout,
    output logic [1:0]         count
);

    logic [1:0][ENTRY_W-1:0] mem;
    logic                    wr_ptr;
    logic                    rd_ptr;
    logic                    do_push;
    logic                    do_pop;

    // Pop only when data exists; push is refused only if full and nothing leaves.
    assign do_pop  = pop & (count != 2'd0);
    assign do_push = push & ((count != 2'd2) | do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem    <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + 2'(do_push) - 2'(do_pop);
        end
    end

endmodule

// File: rtl/interleaver_4_4_ctrl.sv
// Fills a 16-byte frame into interleaver_4_4, reads it back permuted and streams it out with end-of-frame.
module interleaver_4_4_ctrl
    import interleaver_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DW-1:0]     in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DW-1:0]     out_data,
    output logic              out_last,
    output logic              il_write,
    output logic              il_leaver,
    output logic [ADDR_W-1:0] il_addr,
    output logic [DW-1:0]     il_data,
    input  logic [DW-1:0]     il_q,
    output logic              busy
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME - 1);

    state_t             state;
    state_t             state_nxt;
    logic [ADDR_W-1:0]  wr_cnt;
    logic [ADDR_W-1:0]  wr_cnt_nxt;
    logic [ADDR_W-1:0]  rd_cnt;
    logic [ADDR_W-1:0]  rd_cnt_nxt;
    logic               rd_pend;
    logic               pend_last;
    logic               issue;
    logic               pop;
    logic [2:0]         occupancy;
    logic               credit_ok;
    logic [1:0]         fifo_count;
    fifo_entry_t        push_entry;
    fifo_entry_t        head_entry;
    logic [ENTRY_W-1:0] fifo_dout;

    assign out_valid = (fifo_count != 2'd0);
    assign pop       = out_valid & out_ready;
    assign busy      = (state == DRAIN) | out_valid;

    // The slot freed by this cycle's pop is credited so a drain can run at one byte per cycle.
    assign occupancy = 3'(fifo_count) + 3'(rd_pend) - 3'(pop);
    assign credit_ok = (occupancy < 3'd2);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= FILL;
            wr_cnt    <= '0;
            rd_cnt    <= '0;
            rd_pend   <= 1'b0;
            pend_last <= 1'b0;
        end else begin
            state     <= state_nxt;
            wr_cnt    <= wr_cnt_nxt;
            rd_cnt    <= rd_cnt_nxt;
            rd_pend   <= issue;
            pend_last <= issue & (rd_cnt == LAST_ADDR);
        end
    end

    // Next state, counters and the interleaver-side strobes.
    always_comb begin
        state_nxt  = state;
        wr_cnt_nxt = wr_cnt;
        rd_cnt_nxt = rd_cnt;
        in_ready   = 1'b0;
        il_write   = 1'b0;
        il_leaver  = 1'b0;
        il_addr    = '0;
        il_data    = '0;
        issue      = 1'b0;
        case (state)
            FILL: begin
                in_ready = 1'b1;
                il_write = in_valid;
                il_addr  = wr_cnt;
                il_data  = in_data;
                if (in_valid) begin
                    wr_cnt_nxt = wr_cnt + ADDR_W'(1);
                    if (wr_cnt == LAST_ADDR) begin
                        state_nxt = DRAIN;
                    end
                end
            end
            DRAIN: begin
                issue     = credit_ok;
                il_leaver = credit_ok;
                il_addr   = rd_cnt;
                if (credit_ok) begin
                    rd_cnt_nxt = rd_cnt + ADDR_W'(1);
                    if (rd_cnt == LAST_ADDR) begin
                        state_nxt = FILL;
                    end
                end
            end
            default: begin
                state_nxt = FILL;
            end
        endcase
    end

    // Read data arrives one cycle after the leaver strobe and is captured on that cycle.
    assign push_entry = '{last: pend_last, data: il_q};
    assign head_entry = fifo_entry_t'(fifo_dout);
    assign out_data   = head_entry.data;
    assign out_last   = head_entry.last;

    il_out_fifo u_fifo (
        .clk   (clk),
        .rst_n (rst),
        .push  (rd_pend),
        .pop   (pop),
        .din   (push_entry),
        .dout  (fifo_dout),
        .count (fifo_count)
    );

endmodule
